axis_cabs_lanes: RTL and testbench
==================================

# axis_cabs_lanes

Parametrised multi-lane complex-magnitude serializer for the peak-detection path. It accepts one AXI-Stream beat of NUM_CHANNELS packed complex samples and computes a per-channel magnitude using NUM_LANES parallel lanes, stepping through channel groups serially. It emits the original beat alongside the packed magnitudes. Unlike the previous generation, it supports full downstream backpressure through a credit-guarded output FIFO, a selectable magnitude mode, and synchronous active-low reset.

## Interface
- NUM_CHANNELS, 4: complex channels per beat.
- CHANNEL_WIDTH, 64: bits per channel (even). I is in the low half, Q in the high half, both signed, W = CHANNEL_WIDTH/2.
- NUM_LANES, 1: parallel magnitude lanes. Must divide NUM_CHANNELS. G = NUM_CHANNELS/NUM_LANES groups per beat.
- MODE, 2: 0 = |I|+|Q|; 1 = max+(min>>1) (alpha-max-beta-min); 2 = I²+Q².
- CABS_DELAY, 4: lane pipeline latency in cycles. Must be ≥ 3.
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of two and ≥ 2.
- clk  in  1  sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  NUM_CHANNELS*CHANNEL_WIDTH  packed channels, channel 0 in the LSBs.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  NUM_CHANNELS*CHANNEL_WIDTH  copy of the accepted input beat.
- m_axis_tdata_abs  out  NUM_CHANNELS*CHANNEL_WIDTH  per-channel unsigned magnitude, same packing as the input.

## Operation
**Group counter**
- grp runs 0..G-1.
- Issue condition: s_axis_tvalid & credit_ok. On each issue, lane k receives channel grp*NUM_LANES+k.
- grp advances on each issue and wraps to 0 after G-1.

**Input handshake**
- s_axis_tready = issue & (grp == G-1). The beat is consumed only on its last group.
- Upstream holds tdata stable until then.

**Credits**
- credit_ok is evaluated only when grp == 0.
- credit_ok = fifo_count + inflight < FIFO_DEPTH. inflight counts beats that have been accepted but not yet written to the FIFO.
- While grp ≠ 0, credit_ok is held at 1 so a started beat never stalls mid-group.
- The FIFO therefore never overflows. No backpressure reaches the lanes.

**Lanes**
- Each lane is a fixed-latency, always-enabled pipeline carrying a valid bit and its group index.
- Results are written into an assembly register at slot group*NUM_LANES+k.

**Data path and FIFO write**
- The accepted s_axis_tdata enters a CABS_DELAY-deep data shift register.
- When the last-group result leaves the lanes, {data, assembly} is written to the FIFO. The last group's results bypass the assembly register on that write.

**Width rules** (each result is zero-extended to CHANNEL_WIDTH)
- MODE 0: W+1 bits.
- MODE 1: W+1 bits.
- MODE 2: 2W bits. (-2^(W-1))² + (-2^(W-1))² = 2^(2W-1) fits. No saturation.

**Simultaneous events**
- A FIFO read and write in the same cycle is legal at any fill level, including full and empty.
- inflight increments and decrements in the same cycle net to zero.

**Reset (rst_n low at a clock edge)**
- Clears grp, inflight, FIFO pointers, all lane valid bits and the assembly register.
- m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tdata_abs = 0, s_axis_tready = 0.
- Beats in flight are discarded. A partially issued beat is re-issued from group 0 after reset.

## Timing
- Input accept cycle is t = the cycle of the group G-1 issue.
- m_axis_tvalid rises at t + CABS_DELAY + 1 if the FIFO was empty. The FIFO is first-word-fall-through with registered outputs.
- Throughput: one beat per G cycles when m_axis_tready = 1.
- s_axis_tready is high only in accept cycles. It is low for cycles 0..G-2 of each beat and while credits are exhausted.
- Output: valid/data are stable while valid & ~ready. A pop and the next entry are presented on the cycle after the handshake.

## Structure
- Shared package: MODE encodings (CABS_MODE_L1, CABS_MODE_AMBM, CABS_MODE_POW) and a width helper returning the result width per mode.
- One sub-module: cabs_lane (W, MODE, CABS_DELAY).
  - Stage 1 computes the absolute values or squares.
  - Stage 2 combines them.
  - The remaining stages are pad registers carrying valid and group index.
- The FIFO is an inline register array.

## Test plan
- NUM_LANES=1, MODE=2, ch0 = (I=3, Q=4), others 0, m_axis_tready=1:
  - accepted at cycle t=3.
  - m_axis_tvalid at t+5.
  - abs ch0 = 25, other channels 0.
  - m_axis_tdata equals the input beat.
- MODE=0 with (3,-4): abs = 7. MODE=1 with (-3,4): abs = 5. MODE=2 with (-2^31, -2^31): abs = 2^63.
- NUM_LANES=4, G=1, 10 back-to-back beats with m_axis_tready=1: s_axis_tready high every cycle, 10 outputs in order.
- m_axis_tready=0 for 40 cycles with a continuous source:
  - exactly FIFO_DEPTH beats accepted, then s_axis_tready stays 0.
  - after release, all beats emerge in order with none lost or duplicated.
- Random m_axis_tready (50%) over 200 beats: scoreboard matches. Output holds stable during stalls.
- rst_n low for 1 cycle mid-beat (grp=2) with 2 entries in the FIFO:
  - next cycle all outputs are 0 and the FIFO is empty.
  - the held beat is re-issued from grp 0 and emerges correctly.

Source files
------------

// File: rtl/axis_cabs_lanes_pkg.sv
// Shared definitions for the complex-magnitude serializer: magnitude mode
// encodings and the per-mode result width.
package axis_cabs_lanes_pkg;

  typedef enum logic [1:0] {
    CABS_MODE_L1   = 2'd0,
    CABS_MODE_AMBM = 2'd1,
    CABS_MODE_POW  = 2'd2
  } cabs_mode_e;

  // Significant bits of a lane result for a W-bit signed I/Q pair.
  function automatic int cabs_result_width(input int mode, input int w);
    return (mode == int'(CABS_MODE_POW)) ? 2 * w : w + 1;
  endfunction

endpackage

// File: rtl/axis_cabs_lanes_lane.sv
// One fixed-latency magnitude lane: stage 1 forms |I|,|Q| or I^2,Q^2, stage 2
// combines them, the remaining stages only delay result, valid and group index.
module cabs_lane
  import axis_cabs_lanes_pkg::*;
#(
  parameter int W          = 32,
  parameter int MODE       = 2,
  parameter int CABS_DELAY = 4,
  parameter int GW         = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [GW-1:0]    in_grp,
  input  logic [2*W-1:0]   in_iq,
  output logic             out_valid,
  output logic [GW-1:0]    out_grp,
  output logic [2*W-1:0]   out_mag
);

  localparam int RW   = cabs_result_width(MODE, W);
  localparam int NPAD = CABS_DELAY - 1;
  localparam logic [2*W-1:0] RES_MASK =
    (RW >= 2 * W) ? {(2 * W){1'b1}} : (((2 * W)'(1) << RW) - (2 * W)'(1));

  logic signed [W-1:0]   i_s, q_s;
  logic signed [2*W-1:0] i_ext, q_ext;
  logic [W-1:0]          abs_i, abs_q;
  logic [2*W-1:0]        a_next, b_next, mag_next;
  logic [2*W-1:0]        a_reg, b_reg;
  logic                  s1_valid_reg;
  logic [GW-1:0]         s1_grp_reg;
  logic                  pad_valid_reg [NPAD];
  logic [GW-1:0]         pad_grp_reg   [NPAD];
  logic [2*W-1:0]        pad_mag_reg   [NPAD];

  assign i_s   = in_iq[W-1:0];
  assign q_s   = in_iq[2*W-1:W];
  assign i_ext = {{W{i_s[W-1]}}, i_s};
  assign q_ext = {{W{q_s[W-1]}}, q_s};
  // Negating the most negative value wraps to 2^(W-1), which is the correct unsigned magnitude.
  assign abs_i = i_s[W-1] ? -i_s : i_s;
  assign abs_q = q_s[W-1] ? -q_s : q_s;

  always_comb begin
    a_next = {{W{1'b0}}, abs_i};
    b_next = {{W{1'b0}}, abs_q};
    if (MODE == int'(CABS_MODE_POW)) begin
      a_next = i_ext * i_ext;
      b_next = q_ext * q_ext;
    end
  end

  always_comb begin
    mag_next = a_reg + b_reg;
    if (MODE == int'(CABS_MODE_AMBM)) begin
      mag_next = (a_reg > b_reg) ? a_reg + (b_reg >> 1) : b_reg + (a_reg >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      for (int i = 0; i < NPAD; i++) pad_valid_reg[i] <= 1'b0;
    end else begin
      s1_valid_reg     <= in_valid;
      pad_valid_reg[0] <= s1_valid_reg;
      for (int i = 1; i < NPAD; i++) pad_valid_reg[i] <= pad_valid_reg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    a_reg          <= a_next;
    b_reg          <= b_next;
    s1_grp_reg     <= in_grp;
    pad_mag_reg[0] <= mag_next;
    pad_grp_reg[0] <= s1_grp_reg;
    for (int i = 1; i < NPAD; i++) begin
      pad_mag_reg[i] <= pad_mag_reg[i-1];
      pad_grp_reg[i] <= pad_grp_reg[i-1];
    end
  end

  assign out_valid = pad_valid_reg[NPAD-1];
  assign out_grp   = pad_grp_reg[NPAD-1];
  assign out_mag   = pad_mag_reg[NPAD-1] & RES_MASK;

endmodule

// File: rtl/axis_cabs_lanes.sv
// Multi-lane complex-magnitude serializer: issues channel groups to the lanes,
// reassembles per-beat magnitudes and queues {beat, magnitudes} in a credit-guarded FIFO.
module axis_cabs_lanes
  import axis_cabs_lanes_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int CHANNEL_WIDTH = 64,
  parameter int NUM_LANES     = 1,
  parameter int MODE          = 2,
  parameter int CABS_DELAY    = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] s_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] m_axis_tdata,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] m_axis_tdata_abs
);

  localparam int G  = NUM_CHANNELS / NUM_LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam int CW = CHANNEL_WIDTH;

  logic [GW-1:0]   grp_reg;
  logic [AW:0]     inflight_reg, fifo_count_reg;
  logic [AW+1:0]   occupancy;
  logic            last_grp, credit_ok, issue, fifo_wr, fifo_rd;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [BW-1:0]   data_sr_reg [CABS_DELAY];
  logic [BW-1:0]   asm_reg, asm_full;
  logic [BW-1:0]   mem_data [FIFO_DEPTH];
  logic [BW-1:0]   mem_abs  [FIFO_DEPTH];
  logic [NUM_LANES-1:0] lane_valid;
  logic [GW-1:0]   lane_grp [NUM_LANES];
  logic [CW-1:0]   lane_mag [NUM_LANES];

  assign last_grp  = (grp_reg == GW'(G - 1));
  assign occupancy = {1'b0, fifo_count_reg} + {1'b0, inflight_reg};
  // Credits are only checked before a beat starts so a started beat never stalls mid-group.
  assign credit_ok = (grp_reg != '0) || (occupancy < (AW + 2)'(FIFO_DEPTH));
  assign issue     = rst_n & s_axis_tvalid & credit_ok;
  assign s_axis_tready = issue & last_grp;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    cabs_lane #(
      .W(CW / 2), .MODE(MODE), .CABS_DELAY(CABS_DELAY), .GW(GW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (issue),
      .in_grp   (grp_reg),
      .in_iq    (s_axis_tdata[(int'(grp_reg) * NUM_LANES + gi) * CW +: CW]),
      .out_valid(lane_valid[gi]),
      .out_grp  (lane_grp[gi]),
      .out_mag  (lane_mag[gi])
    );
  end

  assign fifo_wr = lane_valid[0] & (lane_grp[0] == GW'(G - 1));
  assign fifo_rd = m_axis_tvalid & m_axis_tready;

  // The last group's results go straight into the FIFO word alongside earlier groups.
  always_comb begin
    asm_full = asm_reg;
    for (int k = 0; k < NUM_LANES; k++) begin
      asm_full[((G - 1) * NUM_LANES + k) * CW +: CW] = lane_mag[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grp_reg        <= '0;
      inflight_reg   <= '0;
      fifo_count_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      asm_reg        <= '0;
    end else begin
      if (issue) grp_reg <= last_grp ? '0 : grp_reg + GW'(1);
      inflight_reg   <= inflight_reg + (AW + 1)'(s_axis_tready) - (AW + 1)'(fifo_wr);
      fifo_count_reg <= fifo_count_reg + (AW + 1)'(fifo_wr) - (AW + 1)'(fifo_rd);
      if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (fifo_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      for (int k = 0; k < NUM_LANES; k++) begin
        if (lane_valid[k]) asm_reg[(int'(lane_grp[k]) * NUM_LANES + k) * CW +: CW] <= lane_mag[k];
      end
    end
  end

  // Delay line aligned with the lane latency; its tail holds the beat whose last group is leaving the lanes.
  always_ff @(posedge clk) begin
    data_sr_reg[0] <= s_axis_tdata;
    for (int i = 1; i < CABS_DELAY; i++) data_sr_reg[i] <= data_sr_reg[i-1];
    if (fifo_wr) begin
      mem_data[wr_ptr_reg] <= data_sr_reg[CABS_DELAY-1];
      mem_abs[wr_ptr_reg]  <= asm_full;
    end
  end

  assign m_axis_tvalid    = (fifo_count_reg != '0);
  assign m_axis_tdata     = m_axis_tvalid ? mem_data[rd_ptr_reg] : '0;
  assign m_axis_tdata_abs = m_axis_tvalid ? mem_abs[rd_ptr_reg]  : '0;

endmodule

// File: tb/tb_axis_cabs_lanes.sv
// Directed bench for axis_cabs_lanes: timing, all three magnitude modes,
// back-to-back 4-lane operation, backpressure, random ready and mid-beat reset.
module tb_axis_cabs_lanes;

  localparam int BW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic s_tvalid, s_tready, m_tvalid, m_tready;
  logic [BW-1:0] s_tdata, m_tdata, m_abs;
  logic l1_s_tready, l1_m_tvalid, am_s_tready, am_m_tvalid;
  logic [BW-1:0] l1_m_tdata, l1_abs, am_m_tdata, am_abs;
  logic s4_tvalid, s4_tready, m4_tvalid, m4_tready;
  logic [BW-1:0] s4_tdata, m4_tdata, m4_abs;

  int total = 0;
  int bad   = 0;

  axis_cabs_lanes #(.NUM_LANES(1), .MODE(2)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tdata_abs(m_abs));

  axis_cabs_lanes #(.NUM_LANES(1), .MODE(0)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .s_axis_tvalid(s_tvalid), .s_axis_tready(l1_s_tready),
    .s_axis_tdata(s_tdata), .m_axis_tvalid(l1_m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(l1_m_tdata), .m_axis_tdata_abs(l1_abs));

  axis_cabs_lanes #(.NUM_LANES(1), .MODE(1)) dut_am (
    .clk(clk), .rst_n(rst_n), .s_axis_tvalid(s_tvalid), .s_axis_tready(am_s_tready),
    .s_axis_tdata(s_tdata), .m_axis_tvalid(am_m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(am_m_tdata), .m_axis_tdata_abs(am_abs));

  axis_cabs_lanes #(.NUM_LANES(4), .MODE(2), .FIFO_DEPTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_axis_tvalid(s4_tvalid), .s_axis_tready(s4_tready),
    .s_axis_tdata(s4_tdata), .m_axis_tvalid(m4_tvalid), .m_axis_tready(m4_tready),
    .m_axis_tdata(m4_tdata), .m_axis_tdata_abs(m4_abs));

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkch(input int i, input int q);
    return {q[31:0], i[31:0]};
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] b;
    for (int k = 0; k < 8; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  // Reference I^2+Q^2 per channel.
  function automatic logic [BW-1:0] pow_abs(input logic [BW-1:0] d);
    logic [BW-1:0] r;
    longint i, q;
    for (int k = 0; k < 4; k++) begin
      i = longint'($signed(d[k*64 +: 32]));
      q = longint'($signed(d[k*64+32 +: 32]));
      r[k*64 +: 64] = 64'(i * i + q * q);
    end
    return r;
  endfunction

  int acc_c, val_c;
  logic [BW-1:0] cap_data, cap_abs, cap_l1, cap_am;

  // Sends one beat on the shared source (m_tready=1) and records accept/valid cycles and outputs.
  task automatic one_beat(input logic [BW-1:0] b);
    acc_c = -1;
    val_c = -1;
    s_tdata  = b;
    s_tvalid = 1'b1;
    for (int c = 0; c < 20 && val_c < 0; c++) begin
      @(negedge clk);
      if (s_tready && acc_c < 0) acc_c = c;
      if (m_tvalid) begin
        val_c = c;
        cap_data = m_tdata;
        cap_abs  = m_abs;
        cap_l1   = l1_abs;
        cap_am   = am_abs;
      end
      @(posedge clk); #1;
      if (acc_c >= 0) s_tvalid = 1'b0;
    end
  endtask

  task automatic push_beat(input logic [BW-1:0] b);
    bit ok = 1'b0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    check("push_accept", BW'(ok), BW'(1));
  endtask

  // Continuous source of n random beats; rmode 0 = ready low for 40 cycles, 1 = random ready.
  task automatic stream(input int n, input int rmode);
    logic [BW-1:0] q[$];
    logic [BW-1:0] hd, ha, e;
    bit held = 1'b0;
    bit acc;
    int c = 0, n_acc = 0, n_out = 0;
    s_tdata  = rand_beat();
    s_tvalid = 1'b1;
    m_tready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    while (n_out < n && c < 4000) begin
      @(negedge clk);
      if (rmode == 0 && c == 40) check("stall_accepts", BW'(n_acc), BW'(4));
      if (held) begin
        check("hold_valid", BW'(m_tvalid), BW'(1));
        check("hold_data", m_tdata, hd);
        check("hold_abs", m_abs, ha);
      end
      acc = s_tready;
      if (acc) begin
        q.push_back(s_tdata);
        n_acc++;
      end
      held = m_tvalid && !m_tready;
      hd = m_tdata;
      ha = m_abs;
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          check("out_extra", BW'(m_tvalid), BW'(0));
        end else begin
          e = q.pop_front();
          check("out_data", m_tdata, e);
          check("out_abs", m_abs, pow_abs(e));
        end
        n_out++;
      end
      @(posedge clk); #1;
      c++;
      if (acc) begin
        if (n_acc < n) s_tdata = rand_beat();
        else s_tvalid = 1'b0;
      end
      m_tready = (rmode == 1) ? 1'($urandom_range(0, 1)) : (c >= 40);
    end
    check("stream_count", BW'(n_out), BW'(n));
    check("stream_accepts", BW'(n_acc), BW'(n));
  endtask

  logic [BW-1:0] b1, b2, ba, bb, bc, e4;
  logic [BW-1:0] q4[$];
  int n4_acc, n4_out, post_acc, post_val;
  bit acc4, got;

  initial begin
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    s4_tvalid = 1'b0; s4_tdata = '0; m4_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", BW'(m_tvalid), BW'(0));
    check("rst_m_tdata", m_tdata, '0);
    check("rst_m_abs", m_abs, '0);
    check("rst_s_tready", BW'(s_tready), BW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First beat: (3,4) on channel 0 only.
    b1 = {64'd0, 64'd0, 64'd0, mkch(3, 4)};
    one_beat(b1);
    check("t1_accept_cycle", BW'(acc_c), BW'(3));
    check("t1_valid_cycle", BW'(val_c), BW'(8));
    check("t1_data", cap_data, b1);
    check("t1_abs_pow", cap_abs, {192'd0, 64'd25});
    check("t1_abs_l1", cap_l1, {192'd0, 64'd7});
    check("t1_abs_ambm", cap_am, {192'd0, 64'd5});

    // Sign handling and the most negative corner in every mode.
    b2 = {64'd0, mkch(32'h8000_0000, 32'h8000_0000), mkch(-3, 4), mkch(3, -4)};
    one_beat(b2);
    check("t2_data", cap_data, b2);
    check("t2_abs_pow", cap_abs, {64'd0, 64'h8000_0000_0000_0000, 64'd25, 64'd25});
    check("t2_abs_l1", cap_l1, {64'd0, 64'h1_0000_0000, 64'd7, 64'd7});
    check("t2_abs_ambm", cap_am, {64'd0, 64'hC000_0000, 64'd5, 64'd5});

    // Four lanes, one group per beat: 10 back-to-back beats.
    n4_acc = 0; n4_out = 0;
    s4_tdata = rand_beat(); s4_tvalid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (n4_acc < 10) check("b2b_ready", BW'(s4_tready), BW'(1));
      acc4 = s4_tready;
      if (acc4) begin q4.push_back(s4_tdata); n4_acc++; end
      if (m4_tvalid) begin
        if (q4.size() == 0) begin
          check("b2b_extra", BW'(m4_tvalid), BW'(0));
        end else begin
          e4 = q4.pop_front();
          check("b2b_data", m4_tdata, e4);
          check("b2b_abs", m4_abs, pow_abs(e4));
        end
        n4_out++;
      end
      @(posedge clk); #1;
      if (acc4) begin
        if (n4_acc < 10) s4_tdata = rand_beat();
        else s4_tvalid = 1'b0;
      end
    end
    check("b2b_count", BW'(n4_out), BW'(10));

    stream(8, 0);
    stream(200, 1);

    // Mid-beat reset with two entries queued.
    m_tready = 1'b0;
    repeat (10) @(posedge clk); #1;
    ba = rand_beat(); bb = rand_beat(); bc = rand_beat();
    push_beat(ba);
    push_beat(bb);
    repeat (6) @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_valid", BW'(m_tvalid), BW'(1));
    check("pre_rst_head", m_tdata, ba);
    @(posedge clk); #1;
    s_tdata = bc; s_tvalid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_m_tvalid", BW'(m_tvalid), BW'(0));
    check("mid_rst_m_tdata", m_tdata, '0);
    check("mid_rst_m_abs", m_abs, '0);
    check("mid_rst_s_tready", BW'(s_tready), BW'(0));
    m_tready = 1'b1;
    post_acc = -1; post_val = -1; got = 1'b0;
    for (int c = 1; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (post_acc >= 0) s_tvalid = 1'b0;
      @(negedge clk);
      if (s_tready && post_acc < 0) post_acc = c;
      if (m_tvalid) begin
        got = 1'b1;
        post_val = c;
        check("reissue_data", m_tdata, bc);
        check("reissue_abs", m_abs, pow_abs(bc));
      end
    end
    s_tvalid = 1'b0;
    check("reissue_accept_cycle", BW'(post_acc), BW'(3));
    check("reissue_valid_cycle", BW'(post_val), BW'(8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
